// File: rtl/shift_down_pkg.sv
// Shared definitions for the shift-down instruction bus: field layout,
// FSM state encoding and the beat packing helper.
package shift_down_pkg;

  localparam int CRD_W    = 134;
  localparam int DATA_W   = 128;
  localparam int ID_W     = 5;

  localparam int VLD_BIT  = 133;
  localparam int DATA_MSB = 132;
  localparam int DATA_LSB = 5;
  localparam int ID_MSB   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } sd_state_e;

  // Builds {vld, data, id}; an invalid beat is all zeros so downstream
  // stages always see a clean hold.
  function automatic logic [CRD_W-1:0] pack_beat(
    input logic              vld,
    input logic [DATA_W-1:0] data,
    input logic [ID_W-1:0]   id
  );
    logic [CRD_W-1:0] beat;
    beat = '0;
    if (vld) begin
      beat[VLD_BIT]           = 1'b1;
      beat[DATA_MSB:DATA_LSB] = data;
      beat[ID_MSB:0]          = id;
    end
    return beat;
  endfunction

endpackage

// File: rtl/shift_down_issuer.sv
// Head of the SMC shift-down chain: turns one command into a stream of
// instruction beats (PARAM_UR_WORD_CNT per SMC id over the commanded range),
// optionally spaced by idle gap cycles, then pulses done.
module shift_down_issuer
  import shift_down_pkg::*;
#(
  parameter int PARAM_UR_WORD_CNT = 4,
  parameter int ISSUE_GAP         = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ID_W-1:0]   cmd_first_id,
  input  logic [ID_W-1:0]   cmd_last_id,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              abort,
  output logic [CRD_W-1:0]  crd_shiftdn_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted
);

  localparam logic [7:0] LAST_BEAT = 8'(PARAM_UR_WORD_CNT - 1);
  // Only meaningful when ISSUE_GAP > 0; the GAP state is unreachable otherwise.
  localparam logic [3:0] LAST_GAP  = 4'(ISSUE_GAP - 1);

  sd_state_e         state_q, state_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [CRD_W-1:0]  crd_q, crd_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              aborted_q, aborted_d;

  // cur_id_q/beat_cnt_q describe the beat currently on the bus (state ISSUE).
  logic              last_word;
  logic              final_beat;
  logic [ID_W-1:0]   nxt_id;
  logic [7:0]        nxt_cnt;

  assign last_word  = (beat_cnt_q == LAST_BEAT);
  // Termination is decided on the current id, so the wrap of cur_id past 31
  // is never consulted.
  assign final_beat = (cur_id_q == last_id_q) && last_word;
  assign nxt_id     = last_word ? cur_id_q + 5'd1 : cur_id_q;
  assign nxt_cnt    = last_word ? 8'd0 : beat_cnt_q + 8'd1;

  assign cmd_rdy         = (state_q == IDLE) && !rst;
  assign busy            = (state_q != IDLE);
  assign crd_shiftdn_out = crd_q;
  assign done            = done_q;
  assign err             = err_q;
  assign aborted         = aborted_q;

  // Next-state, counter and registered-output computation for the issuer FSM.
  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    data_d     = data_q;
    cur_id_d   = cur_id_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    crd_d      = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    aborted_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          last_id_d  = cmd_last_id;
          data_d     = cmd_data;
          cur_id_d   = cmd_first_id;
          beat_cnt_d = 8'd0;
          if (cmd_first_id > cmd_last_id) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            crd_d   = pack_beat(1'b1, cmd_data, cmd_first_id);
          end
        end
      end
      ISSUE: begin
        cur_id_d   = nxt_id;
        beat_cnt_d = nxt_cnt;
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (final_beat) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (ISSUE_GAP > 0) begin
          state_d   = GAP;
          gap_cnt_d = 4'd0;
        end else begin
          crd_d = pack_beat(1'b1, data_q, nxt_id);
        end
      end
      GAP: begin
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (gap_cnt_q == LAST_GAP) begin
          state_d = ISSUE;
          crd_d   = pack_beat(1'b1, data_q, cur_id_q);
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_id_q  <= '0;
      data_q     <= '0;
      cur_id_q   <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      crd_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      data_q     <= data_d;
      cur_id_q   <= cur_id_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      crd_q      <= crd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      aborted_q  <= aborted_d;
    end
  end

endmodule

// File: tb/tb_shift_down_issuer.sv
// Directed bench for shift_down_issuer. Two instances (gap 1 and gap 0) share
// the command fields; each has its own cmd_vld. A per-cycle expected trace is
// queued when a command is driven and popped/compared at every falling edge.
module tb_shift_down_issuer;
  import shift_down_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              abort;
  logic              cmd_vld_g1, cmd_vld_g0;
  logic [4:0]        cmd_first_id, cmd_last_id;
  logic [127:0]      cmd_data;

  logic              rdy_g1, busy_g1, done_g1, err_g1, ab_g1;
  logic              rdy_g0, busy_g0, done_g0, err_g0, ab_g0;
  logic [133:0]      crd_g1, crd_g0;

  shift_down_issuer #(.PARAM_UR_WORD_CNT(W), .ISSUE_GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld_g1), .cmd_rdy(rdy_g1),
    .cmd_first_id(cmd_first_id), .cmd_last_id(cmd_last_id), .cmd_data(cmd_data),
    .abort(abort), .crd_shiftdn_out(crd_g1), .busy(busy_g1), .done(done_g1),
    .err(err_g1), .aborted(ab_g1)
  );

  shift_down_issuer #(.PARAM_UR_WORD_CNT(W), .ISSUE_GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld_g0), .cmd_rdy(rdy_g0),
    .cmd_first_id(cmd_first_id), .cmd_last_id(cmd_last_id), .cmd_data(cmd_data),
    .abort(abort), .crd_shiftdn_out(crd_g0), .busy(busy_g0), .done(done_g0),
    .err(err_g0), .aborted(ab_g0)
  );

  typedef struct packed {
    logic [133:0] crd;
    logic         busy;
    logic         rdy;
    logic         done;
    logic         err;
    logic         aborted;
  } obs_t;

  obs_t exp_q1[$];
  obs_t exp_q0[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic obs_t idle_obs(input logic r);
    obs_t o;
    o = '0;
    o.rdy = !r;
    return o;
  endfunction

  function automatic obs_t beat_obs(input logic [127:0] d, input logic [4:0] id);
    obs_t o;
    o = '0;
    o.crd  = {1'b1, d, id};
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t gap_obs();
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t done_obs(input logic e, input logic a);
    obs_t o;
    o = '0;
    o.busy    = 1'b1;
    o.done    = 1'b1;
    o.err     = e;
    o.aborted = a;
    return o;
  endfunction

  task automatic push(input logic sel, input obs_t o);
    if (sel) exp_q1.push_back(o);
    else     exp_q0.push_back(o);
  endtask

  // Expected cycle-by-cycle trace starting the cycle after acceptance.
  // abort_k >= 0 means abort is sampled at the end of beat abort_k's cycle.
  task automatic push_trace(input logic sel, input int g, input logic [4:0] first,
                            input logic [4:0] last, input logic [127:0] d,
                            input int abort_k);
    int nb;
    if (first > last) begin
      push(sel, done_obs(1'b1, 1'b0));
      return;
    end
    nb = (int'(last) - int'(first) + 1) * W;
    for (int k = 0; k < nb; k++) begin
      push(sel, beat_obs(d, 5'(int'(first) + k / W)));
      if (k == abort_k) begin
        push(sel, done_obs(1'b0, 1'b1));
        return;
      end
      if (k < nb - 1)
        for (int j = 0; j < g; j++) push(sel, gap_obs());
    end
    push(sel, done_obs(1'b0, 1'b0));
  endtask

  task automatic check_dut(input string tag, input obs_t e, input obs_t o);
    total++;
    assert (o.crd === e.crd) else begin
      bad++;
      $error("FAIL %s_bus cyc=%0d got=%h exp=%h", tag, cyc, o.crd, e.crd);
    end
    total++;
    assert ({o.busy, o.rdy, o.done, o.err, o.aborted} ===
            {e.busy, e.rdy, e.done, e.err, e.aborted}) else begin
      bad++;
      $error("FAIL %s_ctrl(busy,rdy,done,err,aborted) cyc=%0d got=%b exp=%b", tag, cyc,
             {o.busy, o.rdy, o.done, o.err, o.aborted},
             {e.busy, e.rdy, e.done, e.err, e.aborted});
    end
  endtask

  // One clock: sample both DUTs at the falling edge against the scoreboard.
  task automatic cycle();
    obs_t e1, e0, o1, o0;
    @(negedge clk);
    cyc++;
    e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : idle_obs(rst);
    e0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : idle_obs(rst);
    o1 = {crd_g1, busy_g1, rdy_g1, done_g1, err_g1, ab_g1};
    o0 = {crd_g0, busy_g0, rdy_g0, done_g0, err_g0, ab_g0};
    check_dut("g1", e1, o1);
    check_dut("g0", e0, o0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q1.size() > 0 || exp_q0.size() > 0); i++) cycle();
    cycle();
  endtask

  task automatic send(input logic sel, input logic [4:0] first, input logic [4:0] last,
                      input logic [127:0] d, input int abort_k);
    cmd_first_id = first;
    cmd_last_id  = last;
    cmd_data     = d;
    if (sel) cmd_vld_g1 = 1'b1;
    else     cmd_vld_g0 = 1'b1;
    push_trace(sel, sel ? 1 : 0, first, last, d, abort_k);
    cycle();
    cmd_vld_g1 = 1'b0;
    cmd_vld_g0 = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    rst = 1'b1; abort = 1'b0; cmd_vld_g1 = 1'b0; cmd_vld_g0 = 1'b0;
    cmd_first_id = '0; cmd_last_id = '0; cmd_data = '0;

    // Reset held two cycles, then ready in the first cycle after release.
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Single SMC id 3, gap 1: beats at N+1,3,5,7, done at N+8.
    send(1'b1, 5'd3, 5'd3, {16{8'hA5}}, -1);
    drain();

    // Range 2..4, no gap: 12 back-to-back beats, done at N+13.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, 5'd2, 5'd4, d, -1);
    drain();

    // Empty range: done+err at N+1, ready again at N+2.
    send(1'b1, 5'd5, 5'd2, {4{32'h1234_5678}}, -1);
    drain();

    // Abort ignored while idle.
    abort = 1'b1;
    cycle(); cycle();
    abort = 1'b0;

    // Abort during the 3rd beat (cycle N+5 with gap 1): done+aborted at N+6.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, 5'd0, 5'd1, d, 2);
    repeat (4) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    drain();
    send(1'b1, 5'd1, 5'd1, ~d, -1);
    drain();

    // Top of id range: 30..31 gives 8 beats and stops.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, 5'd30, 5'd31, d, -1);
    drain();
    send(1'b1, 5'd31, 5'd31, ~d, -1);
    drain();

    // Reset mid-sequence: outputs clear next cycle, no done afterwards.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, 5'd0, 5'd2, d, -1);
    repeat (3) cycle();
    rst = 1'b1;
    exp_q1.delete();
    cycle();
    rst = 1'b0;
    repeat (6) cycle();

    // cmd_vld held through busy: accepted once now, once more after IDLE.
    d = {$urandom, $urandom, $urandom, $urandom};
    cmd_first_id = 5'd7;
    cmd_last_id  = 5'd7;
    cmd_data     = d;
    cmd_vld_g1   = 1'b1;
    push_trace(1'b1, 1, 5'd7, 5'd7, d, -1);
    push(1'b1, idle_obs(1'b0));
    push_trace(1'b1, 1, 5'd7, 5'd7, d, -1);
    repeat (10) cycle();
    cmd_vld_g1 = 1'b0;
    drain();
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
